// File: rtl/cache_fill_fsm.sv
// ============================================================================
// Module  : cache_fill_fsm
// Brief   : Cache block fill engine. Issues one read per cycle for an aligned
//           block and streams the returned words into the data array, then
//           pulses the tag write. Optional macro: CRITICAL_WORD_FIRST_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_WIDTH-1:0]              miss_address,
  input  logic                               memory_data_valid,
  input  logic [15:0]                        memory_data_in,
  output logic                               fsm_busy,
  output logic                               memory_enable,
  output logic                               memory_wr,
  output logic [ADDR_WIDTH-1:0]              memory_address,
  output logic                               write_data_array,
  output logic                               write_tag_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] cache_word_index,
  output logic [15:0]                        cache_data_out
);

  localparam int c_IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int c_CNT_W = c_IDX_W + 1;
  localparam int c_OFF_W = c_IDX_W + 1;
  localparam logic [ADDR_WIDTH-1:0] c_OFF_MASK = ADDR_WIDTH'((2 * WORDS_PER_BLOCK) - 1);
  localparam logic [c_CNT_W-1:0]    c_WPB      = c_CNT_W'(WORDS_PER_BLOCK);
  localparam logic [c_CNT_W-1:0]    c_LAST     = c_CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t                r_state;
  logic [c_CNT_W-1:0]    r_issue_cnt;
  logic [c_CNT_W-1:0]    r_recv_cnt;
  logic [ADDR_WIDTH-1:0] r_base;

  logic                  w_in_fill;
  logic                  w_mem_en;
  logic                  w_wr_data;
  logic                  w_last;
  logic [c_IDX_W-1:0]    w_off;
  logic [c_IDX_W-1:0]    w_req_word;
  logic [c_IDX_W-1:0]    w_rcv_word;
  logic [ADDR_WIDTH-1:0] w_req_addr;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [c_IDX_W-1:0]    r_word_off;
  assign w_off = r_word_off;
`else
  assign w_off = '0;
`endif

  assign w_in_fill  = (r_state == S_FILL);
  assign w_mem_en   = w_in_fill && (r_issue_cnt < c_WPB);
  assign w_wr_data  = w_in_fill && memory_data_valid;
  assign w_last     = w_wr_data && (r_recv_cnt == c_LAST);

  // Word slots wrap naturally within c_IDX_W bits, giving the modulo order.
  assign w_req_word = w_off + r_issue_cnt[c_IDX_W-1:0];
  assign w_rcv_word = w_off + r_recv_cnt[c_IDX_W-1:0];
  assign w_req_addr = r_base + {{(ADDR_WIDTH-c_IDX_W-1){1'b0}}, w_req_word, 1'b0};

  assign fsm_busy         = w_in_fill || ((r_state == S_IDLE) && miss_detected);
  assign memory_enable    = w_mem_en;
  assign memory_wr        = 1'b0;
  assign memory_address   = w_mem_en ? w_req_addr : '0;
  assign write_data_array = w_wr_data;
  assign write_tag_array  = w_last;
  assign cache_word_index = w_wr_data ? w_rcv_word : '0;
  assign cache_data_out   = memory_data_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_base      <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      r_word_off  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (miss_detected) begin
            r_base      <= miss_address & ~c_OFF_MASK;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_state     <= S_FILL;
`ifdef CRITICAL_WORD_FIRST_EN
            r_word_off  <= miss_address[c_OFF_W-1:1];
`endif
          end
        end
        S_FILL: begin
          if (w_mem_en) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
          end
          if (w_wr_data) begin
            r_recv_cnt <= r_recv_cnt + 1'b1;
          end
          if (w_last) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
// ============================================================================
// Module  : tb_cache_fill_fsm
// Brief   : Randomized self-checking bench for cache_fill_fsm against a
//           cycle-schedule reference model. Honours CRITICAL_WORD_FIRST_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_fill_fsm;

  localparam int AW = 16;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_detected;
  logic [AW-1:0] miss_address;
  logic          memory_data_valid;
  logic [15:0]   memory_data_in;
  logic          fsm_busy;
  logic          memory_enable;
  logic          memory_wr;
  logic [AW-1:0] memory_address;
  logic          write_data_array;
  logic          write_tag_array;
  logic [2:0]    cache_word_index;
  logic [15:0]   cache_data_out;

  int n_vec = 0;
  int n_err = 0;

  cache_fill_fsm #(
    .ADDR_WIDTH      (AW),
    .WORDS_PER_BLOCK (W)
  ) u_dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data_in    (memory_data_in),
    .fsm_busy          (fsm_busy),
    .memory_enable     (memory_enable),
    .memory_wr         (memory_wr),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .cache_word_index  (cache_word_index),
    .cache_data_out    (cache_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_cycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst               = 1'b0;
      miss_detected     = 1'b0;
      miss_address      = AW'($urandom);
      memory_data_valid = stray;
      memory_data_in    = 16'hBEEF;
      @(negedge clk);
      chk("idle_busy", 32'(fsm_busy), 32'd0);
      chk("idle_men",  32'(memory_enable), 32'd0);
      chk("idle_wda",  32'(write_data_array), 32'd0);
      chk("idle_tag",  32'(write_tag_array), 32'd0);
      chk("idle_mwr",  32'(memory_wr), 32'd0);
    end
  endtask

  // One miss at cycle 0, fixed response latency; optional stray miss in the
  // fill and optional reset after abort_after data writes.
  task automatic run_fill(input logic [AW-1:0] a, input int lat, input int abort_after,
                          input logic [AW-1:0] stray_miss);
    logic [AW-1:0] base;
    logic [AW-1:0] ea;
    int w, last, writes, tags, busy_cnt, j, k;
    bit aborted, vld;
    base = a & ~AW'(2 * W - 1);
`ifdef CRITICAL_WORD_FIRST_EN
    w = int'(a >> 1) % W;
`else
    w = 0;
`endif
    last     = lat + W;
    writes   = 0;
    tags     = 0;
    busy_cnt = 0;
    aborted  = 1'b0;
    for (int c = 0; c <= last + 1; c++) begin
      @(posedge clk); #1;
      rst           = 1'b0;
      miss_detected = (c == 0);
      miss_address  = (c == 0) ? a : AW'($urandom);
      if (c == 3 && abort_after == 0) begin
        miss_detected = 1'b1;
        miss_address  = stray_miss;
      end
      j   = c - 1 - lat;
      vld = (j >= 0 && j < W);
      memory_data_valid = vld;
      memory_data_in    = 16'($urandom);
      if (abort_after > 0 && !aborted && writes == abort_after && vld) begin
        rst     = 1'b1;
        aborted = 1'b1;
      end
      @(negedge clk);
      if (rst) continue;
      writes   += int'(write_data_array);
      tags     += int'(write_tag_array);
      busy_cnt += int'(fsm_busy);
      if (aborted) begin
        chk("abort_busy", 32'(fsm_busy), 32'd0);
        chk("abort_men",  32'(memory_enable), 32'd0);
        chk("abort_wda",  32'(write_data_array), 32'd0);
        chk("abort_tag",  32'(write_tag_array), 32'd0);
      end else begin
        k = c - 1;
        chk("busy", 32'(fsm_busy), 32'(c <= last));
        chk("men",  32'(memory_enable), 32'(k >= 0 && k < W));
        chk("mwr",  32'(memory_wr), 32'd0);
        if (k >= 0 && k < W) begin
          ea = base + AW'(2 * ((w + k) % W));
          chk("maddr", 32'(memory_address), 32'(ea));
        end
        chk("wda", 32'(write_data_array), 32'(vld));
        chk("tag", 32'(write_tag_array), 32'(vld && j == W - 1));
        if (vld) begin
          chk("idx",  32'(cache_word_index), 32'((w + j) % W));
          chk("data", 32'(cache_data_out), 32'(memory_data_in));
        end
      end
    end
    chk("n_writes", 32'(writes), 32'(aborted ? abort_after : W));
    chk("n_tags",   32'(tags),   32'(aborted ? 0 : 1));
    if (!aborted) chk("busy_len", 32'(busy_cnt), 32'(lat + W + 1));
  endtask

  initial begin
    int lat, ab;
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = '0;
    memory_data_valid = 1'b0;
    memory_data_in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(fsm_busy), 32'd0);
    chk("rst_men",  32'(memory_enable), 32'd0);
    chk("rst_addr", 32'(memory_address), 32'd0);
    chk("rst_idx",  32'(cache_word_index), 32'd0);
    chk("rst_wda",  32'(write_data_array), 32'd0);
    chk("rst_tag",  32'(write_tag_array), 32'd0);

    idle_cycles(5, 1'b0);
    idle_cycles(2, 1'b1);

    run_fill(16'h1236, 4, 0, 16'h4000);
    run_fill(16'h4000, 2, 0, 16'h1230);
    run_fill(16'h1236, 1, 0, 16'h4000);
    run_fill(16'h1236, 3, 3, 16'h0000);
    idle_cycles(2, 1'b1);
    run_fill(16'h123A, 2, 0, 16'h5550);
    run_fill(16'hFFF6, 2, 0, 16'h0010);

    // Reset coinciding with a miss must not start a fill.
    @(posedge clk); #1;
    rst           = 1'b1;
    miss_detected = 1'b1;
    miss_address  = 16'h2222;
    @(posedge clk); #1;
    rst           = 1'b0;
    miss_detected = 1'b0;
    @(negedge clk);
    chk("rstmiss_busy", 32'(fsm_busy), 32'd0);
    chk("rstmiss_men",  32'(memory_enable), 32'd0);
    idle_cycles(2, 1'b1);

    for (int t = 0; t < 25; t++) begin
      lat = $urandom_range(1, 6);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : 0;
      run_fill(AW'($urandom), lat, ab, AW'($urandom));
      idle_cycles($urandom_range(0, 2), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Initiator side of the byte-addressable 16-bit word memory interface.
- On a cache miss, issues read requests for one aligned block to a pipelined memory, one word per cycle.
- Streams each returned word into the cache data array with its word index, then writes the tag.
- Sits between the I-cache/D-cache arrays and the multi-cycle main memory; its busy output stalls the pipeline.

Parameters:
- ADDR_WIDTH, 16, byte-address width.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two, ≥2; block = 2*WORDS_PER_BLOCK bytes.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- miss_detected  input  1  cache reports a miss this cycle.
- miss_address  input  ADDR_WIDTH  byte address that missed.
- memory_data_valid  input  1  memory returns one read word this cycle.
- memory_data_in  input  16  word returned by memory.
- fsm_busy  output  1  fill in progress; stall requester.
- memory_enable  output  1  read request valid this cycle.
- memory_wr  output  1  always 0; the block only reads.
- memory_address  output  ADDR_WIDTH  byte address of the current request; bit 0 always 0.
- write_data_array  output  1  write cache_data_out into the data array at cache_word_index.
- write_tag_array  output  1  write tag for the block; one-cycle pulse.
- cache_word_index  output  log2(WORDS_PER_BLOCK)  word slot for the current data write.
- cache_data_out  output  16  equals memory_data_in (combinational pass-through).

Behaviour:
- States: IDLE, FILL.
- Reset values (registered state):
  - state = IDLE; issue_cnt = 0; recv_cnt = 0; base = 0.
- Resulting reset output values:
  - memory_enable, write_data_array, write_tag_array, memory_wr = 0.
  - memory_address = 0; cache_word_index = 0.
  - fsm_busy = 0 unless miss_detected is high.
- fsm_busy = (state==FILL) | (state==IDLE & miss_detected); it is asserted combinationally in the miss cycle.
- IDLE:
  - On miss_detected, latch base = miss_address with the low log2(2*WORDS_PER_BLOCK) bits cleared.
  - Clear both counters and go to FILL.
  - memory_data_valid in IDLE is ignored: no array writes.
- FILL, request side:
  - memory_enable = (issue_cnt < WORDS_PER_BLOCK).
  - memory_address = base + 2*issue_cnt.
  - issue_cnt increments each cycle memory_enable is high.
  - Exactly WORDS_PER_BLOCK requests are issued, in consecutive cycles starting the cycle after the miss.
- FILL, response side:
  - Each cycle memory_data_valid is high: write_data_array = 1, cache_word_index = recv_cnt, and recv_cnt increments.
  - Responses are in request order.
  - Responses may overlap with issue; any latency of 1 or more cycles is legal.
- Completion:
  - The valid cycle with recv_cnt == WORDS_PER_BLOCK-1 also asserts write_tag_array for that one cycle.
  - Next state is IDLE, so fsm_busy drops the following cycle.
- miss_detected while in FILL is ignored; no re-latch.
- memory_data_valid after all words are received and before return to IDLE cannot occur; the next response returns the FSM to IDLE.
- Address wrap: base + 2*issue_cnt is computed modulo 2^ADDR_WIDTH; an aligned block never crosses the top.
- rst mid-fill:
  - Abort next edge: state IDLE, counters 0.
  - No tag write occurs; a partial block is left untagged.
  - Memory responses arriving after reset are ignored.
- rst and miss_detected in the same cycle: reset wins, no fill starts.

Optional Feature:
- CRITICAL_WORD_FIRST_EN defined:
  - Requests start at the missed word w = miss_address word offset.
  - Request order is w, w+1, … modulo WORDS_PER_BLOCK.
  - cache_word_index = (w + recv_cnt) mod WORDS_PER_BLOCK.
  - Count, latency and tag-pulse timing are unchanged.
- Undefined: requests always run from word 0 upward, as described in Behaviour.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, fsm_busy 0; a stray memory_data_valid=1 with data 0xBEEF -> no write_data_array.
- miss_address=0x1236, memory latency 4 -> fsm_busy 1 in the miss cycle; memory_address 0x1230,0x1232,…,0x123E over 8 consecutive cycles.
  - 8 data writes follow, index 0..7, data matching memory; write_tag_array on the 8th valid; fsm_busy 0 the next cycle.
- Same miss, latency 1 with back-to-back valids -> total busy = 1 + 8 + 1 cycles, 8 data writes, 1 tag pulse.
- Second miss_detected (0x4000) during the fill of 0x1230 -> ignored; a new miss after return to IDLE fetches 0x4000..0x400E.
- rst asserted after 3 data writes -> next cycle IDLE; no tag write; the remaining 5 valids are ignored.
- With CRITICAL_WORD_FIRST_EN, miss 0x123A -> addresses 0x123A,0x123C,0x123E,0x1230,…,0x1238; indices 5,6,7,0,…,4.
